// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//   state_t         FSM state encoding (IDLE/HDR/LOAD/DONE)
//   BYTES_PER_WORD  bytes per instruction word
//   WORD_WIDTH      instruction word width in bits
package program_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk, rst       clock, async active-high reset
//   clear          restart assembly at byte 0 (load start)
//   byte_valid     in_byte is consumed this cycle
//   in_byte        stream byte
//   word           assembled word including the byte offered this cycle
//   word_complete  strobe: this cycle's byte completes a word
module word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            in_byte,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_complete
);

  logic [1:0]            idx_q;
  logic [WORD_WIDTH-1:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (byte_valid) begin
      idx_q                         <= idx_q + 2'd1;
      asm_q[{idx_q, 3'b000} +: 8]   <= in_byte;
    end
  end

  // The 4th byte is merged combinationally so the top can register the
  // complete word in the same cycle the byte is transferred.
  always_comb begin
    word                          = asm_q;
    word[{idx_q, 3'b000} +: 8]    = in_byte;
    word_complete                 = byte_valid && (idx_q == 2'd3);
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: turns a byte stream (word count header, then little-endian
// 32-bit words) into program memory writes while holding the CPU off.
//   clk, rst        clock, async active-high reset
//   start           load request, honoured only in IDLE
//   in_data/valid   stream byte / valid; in_ready = loader accepts
//   w_en/addr/data  program memory write port
//   cpu_hold        CPU held while a load is in progress
//   done            one-cycle completion pulse
//   err             header rejected (sticky until next accepted start)
//
// state | meaning
// IDLE  | waiting for start, word address parked at LOAD_BASE
// HDR   | waiting for the word-count byte
// LOAD  | assembling and writing words
// DONE  | done pulse, back to IDLE
module program_loader
  import program_loader_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int LOAD_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  w_en,
  output logic [PC_WIDTH-1:0]   addr,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  // Largest word count that fits between LOAD_BASE and the top of memory.
  localparam int unsigned CAP = ((1 << PC_WIDTH) - LOAD_BASE) / BYTES_PER_WORD;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]   waddr_q, waddr_d;

  logic                  in_ready_d, w_en_d, cpu_hold_d, done_d, err_d;
  logic [PC_WIDTH-1:0]   addr_d;
  logic [WORD_WIDTH-1:0] data_d;

  logic                  xfer;
  logic                  asm_clear;
  logic [WORD_WIDTH-1:0] asm_word;
  logic                  word_complete;

  assign xfer = in_valid && in_ready;

  word_assembler u_word_assembler (
    .clk           (clk),
    .rst           (rst),
    .clear         (asm_clear),
    .byte_valid    (xfer && (state_q == ST_LOAD)),
    .in_byte       (in_data),
    .word          (asm_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    in_ready_d = 1'b0;
    w_en_d     = 1'b0;
    addr_d     = addr;
    data_d     = data;
    cpu_hold_d = cpu_hold;
    done_d     = 1'b0;
    err_d      = err;
    asm_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        waddr_d = LOAD_BASE[PC_WIDTH-1:0];
        cnt_d   = '0;
        if (start) begin
          state_d    = ST_HDR;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          in_ready_d = 1'b1;
          asm_clear  = 1'b1;
        end
      end

      ST_HDR: begin
        in_ready_d = 1'b1;
        if (xfer) begin
          n_d = in_data;
          if (in_data == 8'd0) begin
            state_d    = ST_DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else if (32'(in_data) > CAP) begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b0;
            err_d      = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (word_complete) begin
          w_en_d  = 1'b1;
          addr_d  = waddr_q;
          data_d  = asm_word;
          waddr_d = waddr_q + PC_WIDTH'(BYTES_PER_WORD);
          cnt_d   = cnt_q + 8'd1;
          // Stop accepting once the last word is in; nothing more belongs to this load.
          if (cnt_q + 8'd1 == n_q) in_ready_d = 1'b0;
        end
        // cnt_q already counts the word being written this cycle.
        if (w_en && (cnt_q == n_q)) begin
          state_d    = ST_DONE;
          in_ready_d = 1'b0;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      cnt_q    <= '0;
      waddr_q  <= LOAD_BASE[PC_WIDTH-1:0];
      in_ready <= 1'b0;
      w_en     <= 1'b0;
      addr     <= '0;
      data     <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      in_ready <= in_ready_d;
      w_en     <= w_en_d;
      addr     <= addr_d;
      data     <= data_d;
      cpu_hold <= cpu_hold_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (LOAD_BASE 0 and 12) driven by
// randomized byte streams; writes, pulses and latencies are compared with
// expectations computed from the stream itself.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int PCW = 8;
  localparam int EV_XFER = 0, EV_WEN = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int          d;
    int          kind;
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_v    [2];
  logic [7:0]     in_data_v  [2];
  logic           in_valid_v [2];
  logic           in_ready_v [2];
  logic           w_en_v     [2];
  logic [PCW-1:0] addr_v     [2];
  logic [31:0]    data_v     [2];
  logic           cpu_hold_v [2];
  logic           done_v     [2];
  logic           err_v      [2];

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  ev_t ev_q[$];
  bit  prev_wen [2];
  bit  prev_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(.PC_WIDTH(PCW), .LOAD_BASE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .w_en(w_en_v[0]),
    .addr(addr_v[0]), .data(data_v[0]), .cpu_hold(cpu_hold_v[0]),
    .done(done_v[0]), .err(err_v[0])
  );

  program_loader #(.PC_WIDTH(PCW), .LOAD_BASE(12)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .w_en(w_en_v[1]),
    .addr(addr_v[1]), .data(data_v[1]), .cpu_hold(cpu_hold_v[1]),
    .done(done_v[1]), .err(err_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int base_of(input int d);
    return (d == 0) ? 0 : 12;
  endfunction

  function automatic int count_ev(input int d, input int kind);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].d == d && ev_q[i].kind == kind) c++;
    return c;
  endfunction

  function automatic ev_t get_ev(input int d, input int kind, input int idx);
    ev_t r = '{0, -1, 0, 0, 32'd0};
    int  c = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].d == d && ev_q[i].kind == kind) begin
        if (c == idx) r = ev_q[i];
        c++;
      end
    end
    return r;
  endfunction

  // Event monitor, sampled mid-cycle. cyc is the index of the current cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        if (in_valid_v[d] && in_ready_v[d])
          ev_q.push_back('{d, EV_XFER, cyc, 0, 32'(in_data_v[d])});
        if (w_en_v[d]) begin
          ev_q.push_back('{d, EV_WEN, cyc, int'(addr_v[d]), data_v[d]});
          chk("hold_at_wen", 32'(cpu_hold_v[d]), 32'd1);
          chk("wen_single_cycle", 32'(prev_wen[d]), 32'd0);
        end
        if (done_v[d]) begin
          ev_q.push_back('{d, EV_DONE, cyc, 0, 32'd0});
          chk("hold_at_done", 32'(cpu_hold_v[d]), 32'd0);
          chk("ready_at_done", 32'(in_ready_v[d]), 32'd0);
        end
        if (err_v[d] && !prev_err[d])
          ev_q.push_back('{d, EV_ERR, cyc, 0, 32'd0});
      end
      prev_wen[d] = w_en_v[d];
      prev_err[d] = err_v[d];
    end
  end

  // Called just after a rising edge; returns just after the edge that took it.
  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, output bit ok);
    int waitc = 0;
    ok = 1'b0;
    in_data_v[d]  = b;
    in_valid_v[d] = 1'b1;
    while (!ok && waitc < 50) begin
      @(negedge clk);
      if (in_ready_v[d]) ok = 1'b1;
      else waitc++;
    end
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    chk({tag, "_in_ready"}, 32'(in_ready_v[d]), 32'd0);
    chk({tag, "_w_en"},     32'(w_en_v[d]),     32'd0);
    chk({tag, "_addr"},     32'(addr_v[d]),     32'd0);
    chk({tag, "_data"},     data_v[d],          32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold_v[d]), 32'd0);
    chk({tag, "_done"},     32'(done_v[d]),     32'd0);
    chk({tag, "_err"},      32'(err_v[d]),      32'd0);
  endtask

  task automatic make_rand(input int n, output logic [7:0] q[$]);
    q = {};
    q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  // One complete load on instance d, checked against the stream contents.
  task automatic run_load(input int d, input logic [7:0] bytes[$],
                          input int stall_lo, input int stall_hi, input bit poke_start);
    int  base    = base_of(d);
    int  n       = int'(bytes[0]);
    int  cap     = (256 - base) / 4;
    bit  exp_err = (n > cap);
    int  nw      = exp_err ? 0 : n;
    int  sent    = (exp_err || n == 0) ? 1 : 1 + 4 * n;
    int  budget  = 0;
    int  nwen;
    bit  ok;
    ev_t w, x, e, hx;
    logic [31:0] exp_data;

    ev_q.delete();
    pulse_start(d);
    chk("hold_rise", 32'(cpu_hold_v[d]), 32'd1);
    chk("err_cleared_by_start", 32'(err_v[d]), 32'd0);
    chk("ready_in_hdr", 32'(in_ready_v[d]), 32'd1);

    for (int i = 0; i < sent; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(stall_hi, stall_lo)) @(posedge clk);
        #1;
      end
      if (poke_start && i == 3) pulse_start(d);
      send_byte(d, bytes[i], ok);
      chk("byte_accepted", 32'(ok), 32'd1);
    end

    while (count_ev(d, exp_err ? EV_ERR : EV_DONE) == 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;

    chk("outcome_seen", 32'(count_ev(d, exp_err ? EV_ERR : EV_DONE)), 32'd1);
    chk("done_count", 32'(count_ev(d, EV_DONE)), exp_err ? 32'd0 : 32'd1);
    chk("err_flag", 32'(err_v[d]), 32'(exp_err));
    chk("hold_after_load", 32'(cpu_hold_v[d]), 32'd0);
    chk("ready_after_load", 32'(in_ready_v[d]), 32'd0);
    chk("xfer_count", 32'(count_ev(d, EV_XFER)), 32'(sent));

    nwen = count_ev(d, EV_WEN);
    chk("wen_count", 32'(nwen), 32'(nw));
    for (int i = 0; i < nw && i < nwen; i++) begin
      w = get_ev(d, EV_WEN, i);
      exp_data = 32'd0;
      for (int k = 0; k < 4; k++) exp_data |= 32'(bytes[1 + 4 * i + k]) << (8 * k);
      chk("wen_addr", 32'(w.addr), 32'((base + 4 * i) % 256));
      chk("wen_data", w.data, exp_data);
      x = get_ev(d, EV_XFER, 4 + 4 * i);
      chk("wen_latency", 32'(w.cyc - x.cyc), 32'd1);
    end

    hx = get_ev(d, EV_XFER, 0);
    if (exp_err && count_ev(d, EV_ERR) > 0) begin
      e = get_ev(d, EV_ERR, 0);
      chk("err_latency", 32'(e.cyc - hx.cyc), 32'd1);
    end else if (!exp_err && count_ev(d, EV_DONE) > 0) begin
      e = get_ev(d, EV_DONE, 0);
      if (n == 0) chk("done_latency_hdr", 32'(e.cyc - hx.cyc), 32'd1);
      else if (nwen > 0) begin
        w = get_ev(d, EV_WEN, nwen - 1);
        chk("done_latency_wen", 32'(e.cyc - w.cyc), 32'd1);
      end
    end
  endtask

  task automatic reset_mid_load();
    logic [7:0] b[$];
    bit ok;
    ev_t w;
    b = {8'h03, 8'hef, 8'hbe, 8'had, 8'hde, 8'h11, 8'h22};
    ev_q.delete();
    pulse_start(0);
    for (int i = 0; i < 5; i++) begin
      send_byte(0, b[i], ok);
      chk("rml_byte_accepted", 32'(ok), 32'd1);
    end
    pulse_start(0);
    chk("ignored_start_hold", 32'(cpu_hold_v[0]), 32'd1);
    chk("ignored_start_ready", 32'(in_ready_v[0]), 32'd1);
    for (int i = 5; i < 7; i++) begin
      send_byte(0, b[i], ok);
      chk("rml_byte_accepted", 32'(ok), 32'd1);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid_load", 0);
    chk("rml_wen_count", 32'(count_ev(0, EV_WEN)), 32'd1);
    w = get_ev(0, EV_WEN, 0);
    chk("rml_wen_addr", 32'(w.addr), 32'd0);
    chk("rml_wen_data", w.data, 32'hdeadbeef);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] s[$];
    int d, n;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i]    = 1'b0;
      in_valid_v[i] = 1'b0;
      in_data_v[i]  = 8'h00;
    end
    repeat (5) @(posedge clk);
    #1;
    check_idle_outputs("in_reset0", 0);
    check_idle_outputs("in_reset1", 1);
    rst = 1'b0;
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'h05;
    repeat (3) begin
      @(posedge clk); #1;
      chk("ready_before_start", 32'(in_ready_v[0]), 32'd0);
    end
    in_valid_v[0] = 1'b0;
    check_idle_outputs("after_reset0", 0);
    check_idle_outputs("after_reset1", 1);

    s = {8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(0, s, 0, 0, 1'b0);
    run_load(1, s, 3, 3, 1'b0);

    s = {8'h41};
    run_load(0, s, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err_v[0]), 32'd1);
    s = {8'h00};
    run_load(0, s, 0, 0, 1'b0);

    make_rand(64, s);
    run_load(0, s, 0, 2, 1'b0);
    make_rand(62, s);
    run_load(1, s, 0, 0, 1'b0);
    make_rand(61, s);
    run_load(1, s, 0, 1, 1'b0);

    repeat (8) begin
      d = int'($urandom_range(1, 0));
      n = int'($urandom_range(8, 1));
      make_rand(n, s);
      run_load(d, s, 0, 2, 1'b1);
    end

    reset_mid_load();
    make_rand(2, s);
    run_load(0, s, 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into `program_memory` before the CPU starts fetching. The block receives a byte stream (valid/ready), assembles little-endian 32-bit instruction words and drives the memory write port (`w_en`, `addr`, `data`). It is the writer end of the memory whose read end is the fetch path. While loading, `cpu_hold` keeps the CPU core held off.

## Interface
- `PC_WIDTH`, 8: width of the program memory byte address.
- `LOAD_BASE`, 0: byte address of the first loaded word. Must be a multiple of 4 and less than 2^PC_WIDTH.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a load. Ignored unless in IDLE.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `w_en`  out  1  program memory write enable.
- `addr`  out  PC_WIDTH  program memory byte address.
- `data`  out  32  program memory write data.
- `cpu_hold`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse at load completion.
- `err`  out  1  header rejected. Sticky until the next accepted `start` or `rst`.

## Operation
- States: IDLE, HDR, LOAD, DONE.
- **IDLE**
  - `start` → HDR.
  - Clears `err`, byte counter and word counter.
  - Sets the address register to `LOAD_BASE`.
  - Asserts `cpu_hold`.
- **HDR**
  - `in_ready` = 1. The first transferred byte is the word count N.
  - CAP = (2^PC_WIDTH − LOAD_BASE)/4.
  - If N = 0: → DONE, with no writes.
  - If N > CAP: `err` = 1, `cpu_hold` = 0, → IDLE, with no writes.
  - Otherwise: → LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Bytes are assembled little-endian: the 1st byte of a word goes to `data[7:0]`, the 4th to `data[31:24]`.
  - On the 4th byte transfer:
    - The complete word is registered to `data`.
    - `w_en` = 1 in the following cycle, with `addr` = current word address.
    - The address then advances by 4 and the word counter increments.
  - Byte acceptance continues during the `w_en` cycle. The assembly register is separate from the `data` output register.
  - After the write of word N: → DONE.
- **DONE**
  - `done` = 1 for one cycle, `cpu_hold` = 0, then → IDLE.
- Address arithmetic is PC_WIDTH-bit unsigned. The CAP check guarantees that no write wraps past 2^PC_WIDTH − 4.
- `start` while not in IDLE is ignored.
- Bytes offered in IDLE or DONE are not accepted (`in_ready` = 0).
- Reset mid-load:
  - Every output is immediately 0 and the state is IDLE.
  - Words already written stay in memory. A partial word is discarded.

## Timing
- Reset values: `in_ready`=0, `w_en`=0, `addr`=0, `data`=0, `cpu_hold`=0, `done`=0, `err`=0.
- All outputs are registered.
- `cpu_hold` rises in the cycle after `start` is sampled.
- Latency from 4th byte transfer to `w_en` is 1 cycle.
- `w_en` is high for exactly 1 cycle per word. `addr`/`data` are stable during that cycle and hold afterwards.
- `done` rises 1 cycle after the final `w_en`, or 1 cycle after the header transfer when N=0.
- `cpu_hold` falls together with `done`.
- `err` rises 1 cycle after the rejecting header transfer.
- Throughput: one byte per cycle, i.e. one word write per 4 cycles with gap-free `in_valid`.
- Stalls: `in_valid` low for any number of cycles simply pauses assembly. There is no timeout.

## Structure
- Shared package:
  - state encoding (IDLE/HDR/LOAD/DONE);
  - BYTES_PER_WORD = 4;
  - WORD_WIDTH = 32.
- Sub-module `word_assembler`:
  - 2-bit byte index plus a 32-bit shift/insert register;
  - outputs `word` and a `word_complete` strobe;
  - cleared on `start` acceptance.
- Top level: FSM, address/word counters, output registers.

## Test plan
- **Reset:**
  - Stimulus: `rst`=1 for 5 cycles, then release.
  - Required: all outputs 0; `in_ready`=0 until `start`.
- **Two-word load, gap-free:**
  - Stimulus: `start`, then bytes 02, 13,00,00,00, 93,00,10,00.
  - Required: `w_en` pulses at `addr`=0 with `data`=0x00000013, then at `addr`=4 with `data`=0x00100093; `done` 1 cycle after the second `w_en`; `cpu_hold` high throughout.
- **Stalls and LOAD_BASE:**
  - Stimulus: `LOAD_BASE`=12; same two-word stream with `in_valid` low for 3 cycles between every byte.
  - Required: writes at `addr`=12 and 16 with identical data; no extra `w_en`.
- **Header limits:**
  - Stimulus: with `PC_WIDTH`=8, header 0x41 (65 > CAP 64), then header 0x00.
  - Required for 0x41: `err`=1, no `w_en`, `cpu_hold`=0.
  - Required for 0x00: `done` pulse, no `w_en`; `err` cleared by that `start`.
- **Full capacity:**
  - Stimulus: header 0x40 with 64 words.
  - Required: last write at `addr`=252, no wrap, `done` pulse.
- **Reset mid-load and ignored start:**
  - Stimulus: `start` pulsed again during LOAD; then `rst` after 2 bytes of word 2.
  - Required: second `start` has no effect; after `rst` all outputs 0, only word 1 written, next `start` restarts at `LOAD_BASE`.
